keypad_scanner: RTL and testbench

Scans a 4x4 key matrix one column at a time and reports each debounced key press as a 4-bit key code plus a one-cycle strobe. It also keeps a 32-bit history of the last eight key codes. The block is the input-side counterpart of the multiplexed seven-segment driver: its Disp_Data output connects directly to that driver's 32-bit Disp_Data input, so typed keys appear on the display nibble by nibble.

---
 rtl/keypad_scanner.sv | 139 +++++++++++++
 tb/tb_keypad_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: one column is driven at a time, presses and releases are debounced,
// and each accepted key is shifted into a 32-bit, eight-code history.
module keypad_scanner #(
  parameter int CLK_DIV  = 50,
  parameter int DEBOUNCE = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Row_In,
  input  logic        Clear,
  output logic [3:0]  Col_Sel,
  output logic [3:0]  Key_Code,
  output logic        Key_Valid,
  output logic        Key_Held,
  output logic [31:0] Disp_Data
);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HOLD, S_RELEASE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  row_s1, rows;
  logic [15:0] div_cnt;
  logic        tick;
  logic [1:0]  col, col_nxt, cap_row, cap_nxt, row_idx;
  logic [3:0]  cnt, cnt_nxt, cnt_inc;
  logic        accept, rel_key;

  assign tick    = (div_cnt == 16'(CLK_DIV - 1));
  assign cnt_inc = cnt + 4'd1;

  // Lowest active row wins when several keys in a column are down.
  always_comb begin
    if (rows[0])      row_idx = 2'd0;
    else if (rows[1]) row_idx = 2'd1;
    else if (rows[2]) row_idx = 2'd2;
    else              row_idx = 2'd3;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    cnt_nxt   = cnt;
    cap_nxt   = cap_row;
    accept    = 1'b0;
    rel_key   = 1'b0;
    if (tick) begin
      case (state)
        S_SCAN: begin
          if (rows == 4'd0) begin
            col_nxt = col + 2'd1;
          end else begin
            cap_nxt = row_idx;
            cnt_nxt = 4'd1;
            if (DEBOUNCE == 1) begin
              accept    = 1'b1;
              state_nxt = S_HOLD;
            end else begin
              state_nxt = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (rows != 4'd0 && row_idx == cap_row) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE)) begin
              accept    = 1'b1;
              state_nxt = S_HOLD;
            end
          end else begin
            col_nxt   = col + 2'd1;
            state_nxt = S_SCAN;
          end
        end
        S_HOLD: begin
          if (!rows[cap_row]) begin
            cnt_nxt = 4'd1;
            if (DEBOUNCE == 1) begin
              rel_key   = 1'b1;
              col_nxt   = col + 2'd1;
              state_nxt = S_SCAN;
            end else begin
              state_nxt = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (!rows[cap_row]) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE)) begin
              rel_key   = 1'b1;
              col_nxt   = col + 2'd1;
              state_nxt = S_SCAN;
            end
          end else begin
            state_nxt = S_HOLD;
          end
        end
        default: state_nxt = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_s1    <= 4'd0;
      rows      <= 4'd0;
      div_cnt   <= 16'd0;
      col       <= 2'd0;
      Col_Sel   <= 4'b0001;
      cnt       <= 4'd0;
      cap_row   <= 2'd0;
      Key_Code  <= 4'd0;
      Key_Valid <= 1'b0;
      Key_Held  <= 1'b0;
      Disp_Data <= 32'd0;
    end else begin
      row_s1    <= Row_In;
      rows      <= row_s1;
      div_cnt   <= tick ? 16'd0 : div_cnt + 16'd1;
      col       <= col_nxt;
      Col_Sel   <= 4'b0001 << col_nxt;
      cnt       <= cnt_nxt;
      cap_row   <= cap_nxt;
      Key_Valid <= accept;
      if (accept) Key_Code <= {cap_nxt, col};
      if (accept)       Key_Held <= 1'b1;
      else if (rel_key) Key_Held <= 1'b0;
      // Clear takes priority over a simultaneous accept.
      if (Clear)       Disp_Data <= 32'd0;
      else if (accept) Disp_Data <= {Disp_Data[27:0], cap_nxt, col};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: an emulated key matrix drives Row_In from Col_Sel, and an
// expected-history queue predicts Disp_Data from the sequence of presses.
module tb_keypad_scanner;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Row_In;
  logic        Clear = 1'b0;
  logic [3:0]  Col_Sel, Key_Code;
  logic        Key_Valid, Key_Held;
  logic [31:0] Disp_Data;

  keypad_scanner #(.CLK_DIV(4), .DEBOUNCE(3)) dut (
    .Clk(Clk), .Reset(Reset), .Row_In(Row_In), .Clear(Clear),
    .Col_Sel(Col_Sel), .Key_Code(Key_Code), .Key_Valid(Key_Valid),
    .Key_Held(Key_Held), .Disp_Data(Disp_Data));

  always #5 Clk = ~Clk;

  // mat[c] = pressed rows in column c; the matrix only answers on the driven column.
  logic [3:0] mat [4];
  logic       use_raw = 1'b1;
  logic [3:0] raw = 4'd0;
  logic [3:0] rows_m;
  always_comb begin
    rows_m = 4'd0;
    for (int c = 0; c < 4; c++) if (Col_Sel[c]) rows_m = rows_m | mat[c];
  end
  assign Row_In = use_raw ? raw : rows_m;

  int n_cmp = 0, n_bad = 0;
  logic [3:0] vq[$];     // observed Key_Code at each Key_Valid
  logic [3:0] hist[$];   // expected key history, newest at back

  always @(negedge Clk) if (!Reset && Key_Valid) vq.push_back(Key_Code);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_disp();
    logic [31:0] d = 32'd0;
    foreach (hist[i]) d = {d[27:0], hist[i]};
    return d;
  endfunction

  task automatic push_hist(input logic [3:0] code);
    hist.push_back(code);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clr_mat();
    for (int c = 0; c < 4; c++) mat[c] = 4'd0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_colsel"}, Col_Sel, 4'b0001);
    chk({p, "_code"},   Key_Code, 4'd0);
    chk({p, "_valid"},  Key_Valid, 1'b0);
    chk({p, "_held"},   Key_Held, 1'b0);
    chk({p, "_disp"},   Disp_Data, 32'd0);
  endtask

  // Waits up to budget cycles for Key_Valid; returns the cycle count (0 = timed out).
  task automatic wait_valid(input int budget, output int k);
    k = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge Clk);
      if (Key_Valid) begin k = i; break; end
    end
  endtask

  task automatic do_press(input string nm, input logic [3:0] mask, input logic [1:0] col,
                          input int hold, input int gap, input logic [3:0] exp_code);
    vq.delete();
    mat[col] = mask;
    cyc(hold);
    chk({nm, "_held"}, Key_Held, 1'b1);
    chk({nm, "_colsel"}, Col_Sel, 4'b0001 << col);
    mat[col] = 4'd0;
    cyc(gap);
    chk({nm, "_nvalid"}, vq.size(), 1);
    if (vq.size() > 0) chk({nm, "_code"}, vq[0], exp_code);
    push_hist(exp_code);
    chk({nm, "_disp"}, Disp_Data, model_disp());
    chk({nm, "_released"}, Key_Held, 1'b0);
  endtask

  typedef struct { logic [3:0] mask; logic [1:0] col; logic [3:0] code; } vec_t;
  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nchg;
    logic [3:0] cur, prev;
    logic ok;
    tbl[0] = '{4'b0100, 2'd1, 4'h9};
    tbl[1] = '{4'b0001, 2'd0, 4'h0};
    tbl[2] = '{4'b1000, 2'd3, 4'hF};
    tbl[3] = '{4'b1010, 2'd0, 4'h4};
    tbl[4] = '{4'b1100, 2'd2, 4'hA};
    tbl[5] = '{4'b0011, 2'd3, 4'h3};
    clr_mat();

    // Reset state with random rows applied
    for (int i = 0; i < 3; i++) begin
      raw = 4'($urandom);
      cyc(2);
      chk_reset($sformatf("reset%0d", i));
    end

    // Idle scan
    use_raw = 1'b0;
    vq.delete();
    @(negedge Clk);
    Reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      if (Col_Sel != 4'b0001) begin k = i; break; end
    end
    chk("idle_first_step", k, 4);
    cur = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      cyc(2);
      chk($sformatf("idle_mid%0d", i), Col_Sel, cur);
      cyc(2);
      cur = {cur[2:0], cur[3]};
      chk($sformatf("idle_step%0d", i), Col_Sel, cur);
    end
    chk("idle_novalid", vq.size(), 0);

    // Clean press at row 2 / column 1 with release timing
    vq.delete();
    mat[1] = 4'b0100;
    cyc(30);
    chk("clean_nvalid", vq.size(), 1);
    if (vq.size() > 0) chk("clean_code", vq[0], 4'h9);
    chk("clean_held", Key_Held, 1'b1);
    chk("clean_colsel", Col_Sel, 4'b0010);
    push_hist(4'h9);
    chk("clean_disp", Disp_Data, 32'h0000_0009);
    mat[1] = 4'd0;
    cyc(9);
    chk("clean_held_late", Key_Held, 1'b1);
    chk("clean_colsel_rel", Col_Sel, 4'b0010);
    cyc(5);
    chk("clean_released", Key_Held, 1'b0);
    prev = Col_Sel; nchg = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (Col_Sel != prev) nchg++;
      prev = Col_Sel;
    end
    chk("clean_rotate", nchg, 4);
    chk("clean_nvalid_end", vq.size(), 1);

    // Single-tick bounce in column 0
    vq.delete();
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (Col_Sel == 4'b0001 && prev != 4'b0001) begin k = i; break; end
      prev = Col_Sel;
    end
    chk("bounce_align", k != 0, 1'b1);
    mat[0] = 4'b0001;
    cyc(4);
    mat[0] = 4'd0;
    cyc(5);
    chk("bounce_resume_col1", Col_Sel, 4'b0010);
    cyc(20);
    chk("bounce_novalid", vq.size(), 0);

    // Release glitch during HOLD
    vq.delete();
    mat[1] = 4'b0010;
    wait_valid(40, k);
    chk("glitch_first_valid", k != 0, 1'b1);
    cyc(4);
    mat[1] = 4'd0;
    cyc(4);
    mat[1] = 4'b0010;
    ok = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      ok = ok & Key_Held;
    end
    chk("glitch_held_steady", ok, 1'b1);
    mat[1] = 4'd0;
    cyc(30);
    chk("glitch_nvalid", vq.size(), 1);
    if (vq.size() > 0) chk("glitch_code", vq[0], 4'h5);
    push_hist(4'h5);
    chk("glitch_disp", Disp_Data, model_disp());

    // Table of single and multi-key presses
    for (int i = 0; i < 6; i++)
      do_press($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].col, 35, 30, tbl[i].code);

    // History of codes 1..9, then Clear on the same edge as a tenth press
    for (int code = 1; code <= 9; code++)
      do_press($sformatf("hist%0d", code), 4'b0001 << (code / 4), 2'(code % 4), 35, 30, 4'(code));
    chk("hist_disp_const", Disp_Data, 32'h2345_6789);
    Clear = 1'b1;
    mat[2] = 4'b0100;
    wait_valid(60, k);
    chk("clear_valid_seen", k != 0, 1'b1);
    chk("clear_disp", Disp_Data, 32'd0);
    chk("clear_code", Key_Code, 4'hA);
    Clear = 1'b0;
    hist.delete();
    cyc(10);
    mat[2] = 4'd0;
    cyc(30);
    chk("clear_disp_after", Disp_Data, model_disp());

    // Multi-key in column 2, reset while HOLD, re-debounce afterward
    mat[2] = 4'b1010;
    wait_valid(40, k);
    chk("multi_valid_seen", k != 0, 1'b1);
    chk("multi_code", Key_Code, 4'h6);
    cyc(5);
    chk("multi_held", Key_Held, 1'b1);
    Reset = 1'b1;
    #1;
    chk_reset("midhold");
    cyc(3);
    Reset = 1'b0;
    hist.delete();
    wait_valid(60, k);
    chk("rehold_latency", k, 20);
    chk("rehold_code", Key_Code, 4'h6);
    mat[2] = 4'd0;
    cyc(30);
    push_hist(4'h6);
    chk("rehold_disp", Disp_Data, model_disp());

    // Random single-column presses; expected row is the lowest pressed one
    for (int i = 0; i < 10; i++) begin
      logic [1:0] c;
      logic [3:0] m;
      int r;
      c = 2'($urandom_range(0, 3));
      m = 4'($urandom_range(1, 15));
      r = 0;
      while (!m[r]) r++;
      do_press($sformatf("rnd%0d", i), m, c, $urandom_range(35, 50), $urandom_range(30, 40),
               {2'(r), c});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
